// File: rtl/pb_event_detect.sv
// pb_event_detect: per-channel synchroniser, debouncer and press/release/long-press FSM for active-low buttons.
// Optional auto-repeat of pressed while long-held: define PB_AUTOREPEAT_EN.
module pb_event_detect #(
    parameter int N_BTN         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 16,
    parameter int LONG_CYCLES   = 1024,
    parameter int REPEAT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pb_n,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] released,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] held,
    output logic             event_any
);
    typedef enum logic [2:0] {IDLE, DEB_P, HELD, LONG, DEB_R} state_t;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    // The IDLE/HELD/LONG sample that starts a debounce counts as the first stable sample.
    localparam logic [DW-1:0] DEB_LIM  = DW'(DEB_CYCLES > 1 ? DEB_CYCLES - 2 : 0);
    localparam logic [HW-1:0] HOLD_LIM = HW'(LONG_CYCLES - 1);
    localparam bit            DEB_ONE  = (DEB_CYCLES == 1);

    logic [N_BTN-1:0] w_press, w_rel, w_long;
    logic             r_event_any;

    if (N_BTN < 1 || SYNC_STAGES < 2 || DEB_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("pb_event_detect: parameter out of range");
    end

    for (genvar c = 0; c < N_BTN; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        state_t                 r_state;
        logic                   r_org_long, r_press, r_rel, r_long, r_held;
        logic [DW-1:0]          r_deb_cnt;
        logic [HW-1:0]          r_hold_cnt;
        logic                   w_s, w_deb_fin, w_rep;
        logic [DW-1:0]          w_deb_inc;
        assign w_s       = r_sync[SYNC_STAGES-1];
        assign w_deb_fin = DEB_ONE || r_deb_cnt >= DEB_LIM;
        assign w_deb_inc = (r_deb_cnt == '1) ? r_deb_cnt : r_deb_cnt + 1'b1;
`ifdef PB_AUTOREPEAT_EN
        localparam int RW = $clog2(REPEAT_CYCLES + 1);
        localparam logic [RW-1:0] REP_LIM = RW'(REPEAT_CYCLES - 1);
        logic [RW-1:0] r_rep_cnt;
        assign w_rep = r_state == LONG && !w_s && r_rep_cnt == REP_LIM;
`else
        assign w_rep = 1'b0;
`endif
        assign w_press[c] = (r_state == IDLE && !w_s && DEB_ONE) || (r_state == DEB_P && !w_s && w_deb_fin) || w_rep;
        assign w_rel[c]   = w_s && (((r_state == HELD || r_state == LONG) && DEB_ONE) || (r_state == DEB_R && w_deb_fin));
        assign w_long[c]  = r_state == HELD && !w_s && r_hold_cnt == HOLD_LIM;
        assign pressed[c]    = r_press;
        assign released[c]   = r_rel;
        assign long_press[c] = r_long;
        assign held[c]       = r_held;

        always_ff @(posedge clk or posedge rst)
            if (rst) r_sync <= '1;
            else     r_sync <= {r_sync[SYNC_STAGES-2:0], pb_n[c]};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state    <= IDLE;
                r_org_long <= 1'b0;
                r_deb_cnt  <= '0;
                r_hold_cnt <= '0;
                r_press    <= 1'b0;
                r_rel      <= 1'b0;
                r_long     <= 1'b0;
                r_held     <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
                r_rep_cnt  <= '0;
`endif
            end else begin
                r_press <= w_press[c];
                r_rel   <= w_rel[c];
                r_long  <= w_long[c];
                r_held  <= r_held ? !w_rel[c] : w_press[c];
                case (r_state)
                    IDLE:
                        if (!w_s) begin
                            r_state    <= DEB_ONE ? HELD : DEB_P;
                            r_deb_cnt  <= '0;
                            r_hold_cnt <= '0;
                        end
                    DEB_P:
                        if (w_s) r_state <= IDLE;
                        else if (w_deb_fin) begin
                            r_state    <= HELD;
                            r_hold_cnt <= '0;
                        end else r_deb_cnt <= w_deb_inc;
                    // A release sample beats the long threshold; hold_cnt stays frozen through DEB_R.
                    HELD:
                        if (w_s) begin
                            r_state    <= DEB_ONE ? IDLE : DEB_R;
                            r_org_long <= 1'b0;
                            r_deb_cnt  <= '0;
                        end else if (r_hold_cnt == HOLD_LIM) begin
                            r_state   <= LONG;
`ifdef PB_AUTOREPEAT_EN
                            r_rep_cnt <= '0;
`endif
                        end else r_hold_cnt <= r_hold_cnt + 1'b1;
                    LONG:
                        if (w_s) begin
                            r_state    <= DEB_ONE ? IDLE : DEB_R;
                            r_org_long <= 1'b1;
                            r_deb_cnt  <= '0;
                        end
`ifdef PB_AUTOREPEAT_EN
                        else r_rep_cnt <= w_rep ? '0 : r_rep_cnt + 1'b1;
`endif
                    DEB_R:
                        if (!w_s) begin
                            r_state   <= r_org_long ? LONG : HELD;
                            r_deb_cnt <= '0;
                        end else if (w_deb_fin) r_state <= IDLE;
                        else r_deb_cnt <= w_deb_inc;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) r_event_any <= 1'b0;
        else     r_event_any <= |{w_press, w_rel, w_long};

    assign event_any = r_event_any;
endmodule

// File: tb/tb_pb_event_detect.sv
// tb_pb_event_detect: directed scenarios for pb_event_detect with N_BTN=2, SYNC=2, DEB=4, LONG=20, REPEAT=8.
module tb_pb_event_detect;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pb_n, pressed, released, long_press, held;
    logic       event_any;
    int         n_cmp = 0, n_err = 0;
`ifdef PB_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    always #5 clk = ~clk;

    pb_event_detect #(.N_BTN(2), .SYNC_STAGES(2), .DEB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .pb_n(pb_n), .pressed(pressed), .released(released),
        .long_press(long_press), .held(held), .event_any(event_any)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drain();
        pb_n = 2'b11;
        repeat (12) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pb_n = 2'b11;
        repeat (3) step();
        n_cmp++; if ({pressed, released, long_press, held, event_any} !== 9'b0) begin n_err++; $display("FAIL reset_outputs: got %b expected 0", {pressed, released, long_press, held, event_any}); end
        rst = 1'b0;
        repeat (2) step();
        n_cmp++; if ({pressed, released, long_press, held, event_any} !== 9'b0) begin n_err++; $display("FAIL post_reset_idle: got %b expected 0", {pressed, released, long_press, held, event_any}); end
    endtask

    task automatic test_clean_press();
        int t_p = -1, n_p = 0, t_r = -1, n_r = 0, n_l = 0;
        logic h5, h6, h15, ev6, hr5, hr6;
        pb_n[0] = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (pressed[0]) begin n_p++; if (t_p < 0) t_p = k; end
            n_l += int'(long_press[0]);
            if (k == 5) h5 = held[0];
            if (k == 6) begin h6 = held[0]; ev6 = event_any; end
            if (k == 15) h15 = held[0];
        end
        pb_n[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (released[0]) begin n_r++; if (t_r < 0) t_r = k; end
            n_l += int'(long_press[0]);
            if (k == 5) hr5 = held[0];
            if (k == 6) hr6 = held[0];
        end
        n_cmp++; if (t_p !== 6) begin n_err++; $display("FAIL clean_press_latency: got %0d expected 6", t_p); end
        n_cmp++; if (n_p !== 1) begin n_err++; $display("FAIL clean_press_count: got %0d expected 1", n_p); end
        n_cmp++; if (h5 !== 1'b0) begin n_err++; $display("FAIL clean_held_before: got %b expected 0", h5); end
        n_cmp++; if (h6 !== 1'b1 || h15 !== 1'b1) begin n_err++; $display("FAIL clean_held_during: got %b%b expected 11", h6, h15); end
        n_cmp++; if (ev6 !== 1'b1) begin n_err++; $display("FAIL clean_event_any: got %b expected 1", ev6); end
        n_cmp++; if (t_r !== 6) begin n_err++; $display("FAIL clean_release_latency: got %0d expected 6", t_r); end
        n_cmp++; if (n_r !== 1) begin n_err++; $display("FAIL clean_release_count: got %0d expected 1", n_r); end
        n_cmp++; if (hr5 !== 1'b1 || hr6 !== 1'b0) begin n_err++; $display("FAIL clean_held_release: got %b%b expected 10", hr5, hr6); end
        n_cmp++; if (n_l !== 0) begin n_err++; $display("FAIL clean_no_long: got %0d expected 0", n_l); end
    endtask

    task automatic test_bounce();
        int n_pulse = 0, n_held = 0, n_ev = 0;
        for (int k = 0; k < 22; k++) begin
            pb_n[0] = !(k < 3 || (k >= 8 && k < 10));
            step();
            n_pulse += int'(pressed[0]) + int'(released[0]) + int'(long_press[0]);
            n_held += int'(held[0]);
            n_ev += int'(event_any);
        end
        n_cmp++; if (n_pulse !== 0) begin n_err++; $display("FAIL bounce_pulses: got %0d expected 0", n_pulse); end
        n_cmp++; if (n_held !== 0) begin n_err++; $display("FAIL bounce_held: got %0d expected 0", n_held); end
        n_cmp++; if (n_ev !== 0) begin n_err++; $display("FAIL bounce_event_any: got %0d expected 0", n_ev); end
    endtask

    task automatic test_release_glitch();
        int t_p = -1, t_l = -1, n_l = 0, n_r = 0, n_drop = 0, n_r2 = 0;
        pb_n[0] = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            step();
            if (pressed[0] && t_p < 0) t_p = k;
            if (long_press[0]) begin n_l++; if (t_l < 0) t_l = k; end
            n_r += int'(released[0]);
            if (k >= 6 && held[0] !== 1'b1) n_drop++;
            if (k == 10) pb_n[0] = 1'b1;
            if (k == 12) pb_n[0] = 1'b0;
        end
        pb_n[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_r2 += int'(released[0]);
        end
        n_cmp++; if (t_p !== 6) begin n_err++; $display("FAIL glitch_press_latency: got %0d expected 6", t_p); end
        n_cmp++; if (n_r !== 0) begin n_err++; $display("FAIL glitch_no_release: got %0d expected 0", n_r); end
        n_cmp++; if (n_drop !== 0) begin n_err++; $display("FAIL glitch_held_drop: got %0d expected 0", n_drop); end
        n_cmp++; if (t_l !== 29) begin n_err++; $display("FAIL glitch_long_resume: got %0d expected 29", t_l); end
        n_cmp++; if (n_l !== 1) begin n_err++; $display("FAIL glitch_long_count: got %0d expected 1", n_l); end
        n_cmp++; if (n_r2 !== 1 || held[0] !== 1'b0) begin n_err++; $display("FAIL glitch_final_release: got %0d/%b expected 1/0", n_r2, held[0]); end
    endtask

    task automatic test_long_hold();
        int t_p = -1, n_p = 0, t_l = -1, n_l = 0, t_r = -1, n_r = 0, n_ch0 = 0;
        pb_n[1] = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            step();
            if (pressed[1]) begin n_p++; if (t_p < 0) t_p = k; end
            if (long_press[1]) begin n_l++; if (t_l < 0) t_l = k; end
            if (released[1]) begin n_r++; if (t_r < 0) t_r = k; end
            n_ch0 += int'(pressed[0]) + int'(released[0]) + int'(long_press[0]) + int'(held[0]);
            if (k == 50) pb_n[1] = 1'b1;
        end
        n_cmp++; if (t_p !== 6) begin n_err++; $display("FAIL long_press_latency: got %0d expected 6", t_p); end
        n_cmp++; if (t_l !== 26) begin n_err++; $display("FAIL long_event_time: got %0d expected 26", t_l); end
        n_cmp++; if (n_l !== 1) begin n_err++; $display("FAIL long_event_count: got %0d expected 1", n_l); end
        n_cmp++; if (n_p !== (AR ? 4 : 1)) begin n_err++; $display("FAIL long_pressed_count: got %0d expected %0d", n_p, AR ? 4 : 1); end
        n_cmp++; if (t_r !== 56 || n_r !== 1) begin n_err++; $display("FAIL long_release: got t=%0d n=%0d expected t=56 n=1", t_r, n_r); end
        n_cmp++; if (n_ch0 !== 0) begin n_err++; $display("FAIL long_channel_isolation: got %0d expected 0", n_ch0); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] p5, p6, r6;
        logic e5, e6, e7;
        pb_n = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 5) begin p5 = pressed; e5 = event_any; end
            if (k == 6) begin p6 = pressed; e6 = event_any; end
            if (k == 7) e7 = event_any;
        end
        pb_n = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 6) r6 = released;
        end
        n_cmp++; if (p5 !== 2'b00 || p6 !== 2'b11) begin n_err++; $display("FAIL simul_pressed: got %b,%b expected 00,11", p5, p6); end
        n_cmp++; if ({e5, e6, e7} !== 3'b010) begin n_err++; $display("FAIL simul_event_any: got %b expected 010", {e5, e6, e7}); end
        n_cmp++; if (r6 !== 2'b11) begin n_err++; $display("FAIL simul_released: got %b expected 11", r6); end
    endtask

    task automatic test_reset_long();
        int t_p = -1, n_p = 0, n_r = 0, t_l = -1;
        int exp_t [3];
        int got_t [3];
        pb_n[1] = 1'b0;
        repeat (30) step();
        n_cmp++; if (held[1] !== 1'b1) begin n_err++; $display("FAIL rstlong_held_before: got %b expected 1", held[1]); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if ({pressed, released, long_press, held, event_any} !== 9'b0) begin n_err++; $display("FAIL rstlong_async_clear: got %b expected 0", {pressed, released, long_press, held, event_any}); end
        repeat (3) begin step(); n_r += int'(released[1]); end
        rst = 1'b0;
        exp_t = '{6, 34, 42};
        got_t = '{-1, -1, -1};
        for (int k = 1; k <= 45; k++) begin
            step();
            if (pressed[1]) begin if (n_p < 3) got_t[n_p] = k; n_p++; if (t_p < 0) t_p = k; end
            if (long_press[1] && t_l < 0) t_l = k;
            n_r += int'(released[1]);
        end
        n_cmp++; if (n_r !== 0) begin n_err++; $display("FAIL rstlong_no_release: got %0d expected 0", n_r); end
        n_cmp++; if (t_p !== 6) begin n_err++; $display("FAIL rstlong_repress_latency: got %0d expected 6", t_p); end
        n_cmp++; if (t_l !== 26) begin n_err++; $display("FAIL rstlong_long_time: got %0d expected 26", t_l); end
        n_cmp++; if (n_p !== (AR ? 3 : 1)) begin n_err++; $display("FAIL rstlong_pressed_count: got %0d expected %0d", n_p, AR ? 3 : 1); end
        if (AR) begin
            n_cmp++; if (got_t[1] !== exp_t[1] || got_t[2] !== exp_t[2]) begin n_err++; $display("FAIL rstlong_repeat_times: got %0d,%0d expected %0d,%0d", got_t[1], got_t[2], exp_t[1], exp_t[2]); end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_long_hold();
        test_simultaneous();
        test_reset_long();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
